// File: rtl/imem_fetch_responder.sv
// imem_fetch_responder
// Instruction-memory responder for the fetch interface. Accepts one PC at a
// time, returns the 32-bit word after LATENCY cycles with a valid/ready
// handshake, flags misaligned/out-of-range PCs as faults (returning NOP),
// supports cancellation by flush, and exposes a load port for program preload.
module imem_fetch_responder #(
    parameter int unsigned DEPTH   = 256,
    parameter int unsigned LATENCY = 2,
    parameter logic [31:0] NOP     = 32'h00000013,
    localparam int unsigned AW     = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [63:0]   req_addr,
    input  logic          flush,
    output logic          resp_valid,
    input  logic          resp_ready,
    output logic [31:0]   resp_instr,
    output logic [63:0]   resp_addr,
    output logic          resp_fault,
    input  logic          ld_en,
    input  logic [AW-1:0] ld_addr,
    input  logic [31:0]   ld_data
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  cnt;
    logic [3:0]  cnt_nxt;
    logic        valid_nxt;

    logic [31:0] mem [DEPTH];

    logic        accept;
    logic        addr_fault;
    logic [AW-1:0] word_idx;

    assign accept     = req_valid & req_ready;
    assign addr_fault = (req_addr[1:0] != 2'b00) || (req_addr[63:2] >= 62'(DEPTH));
    assign word_idx   = req_addr[AW+1:2];

    // Program-load write port; memory contents survive reset.
    always_ff @(posedge clk) begin
        if (ld_en) begin
            mem[ld_addr] <= ld_data;
        end
    end

    // State, latency counter and response-valid registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            resp_valid <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            resp_valid <= valid_nxt;
        end
    end

    // Next-state logic. resp_valid is registered one cycle behind entry to
    // RESP, so RESP is entered LATENCY-1 edges after accept and valid shows
    // LATENCY edges after accept.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        valid_nxt = resp_valid;
        case (state)
            IDLE: begin
                valid_nxt = 1'b0;
                if (accept) begin
                    if (LATENCY == 1) begin
                        state_nxt = RESP;
                        cnt_nxt   = '0;
                    end else begin
                        state_nxt = BUSY;
                        cnt_nxt   = 4'(LATENCY - 1);
                    end
                end
            end
            BUSY: begin
                if (flush) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state_nxt = RESP;
                    end
                end
            end
            RESP: begin
                if (flush) begin
                    state_nxt = IDLE;
                    valid_nxt = 1'b0;
                end else if (resp_valid && resp_ready) begin
                    state_nxt = IDLE;
                    valid_nxt = 1'b0;
                end else begin
                    valid_nxt = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
                valid_nxt = 1'b0;
            end
        endcase
    end

    // Request-side handshake output.
    always_comb begin
        req_ready = (state == IDLE) && !flush;
    end

    // Response payload latched at the accept edge; the memory read sees the
    // pre-write contents when the load port hits the same word on that edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            resp_instr <= '0;
            resp_addr  <= '0;
            resp_fault <= 1'b0;
        end else if (accept) begin
            resp_addr  <= req_addr;
            resp_fault <= addr_fault;
            resp_instr <= addr_fault ? NOP : mem[word_idx];
        end
    end

endmodule

// File: tb/tb_imem_fetch_responder.sv
// Self-checking bench for imem_fetch_responder: table-driven per-cycle
// vectors plus hand-written reset-in-flight and LATENCY=1 sequences.
module tb_imem_fetch_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [63:0] req_addr;
    logic        flush;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_instr;
    logic [63:0] resp_addr;
    logic        resp_fault;
    logic        ld_en;
    logic [7:0]  ld_addr;
    logic [31:0] ld_data;

    // Second instance built with LATENCY=1, sharing clock/reset/flush/load.
    logic        req_valid1;
    logic        req_ready1;
    logic [63:0] req_addr1;
    logic        resp_valid1;
    logic        resp_ready1;
    logic [31:0] resp_instr1;
    logic [63:0] resp_addr1;
    logic        resp_fault1;

    int unsigned passed = 0;
    int unsigned total  = 0;

    always #5 clk = ~clk;

    imem_fetch_responder #(.DEPTH(256), .LATENCY(2), .NOP(32'h00000013)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .flush(flush), .resp_valid(resp_valid),
        .resp_ready(resp_ready), .resp_instr(resp_instr), .resp_addr(resp_addr),
        .resp_fault(resp_fault), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data)
    );

    imem_fetch_responder #(.DEPTH(256), .LATENCY(1), .NOP(32'h00000013)) dut1 (
        .clk(clk), .reset(reset), .req_valid(req_valid1), .req_ready(req_ready1),
        .req_addr(req_addr1), .flush(flush), .resp_valid(resp_valid1),
        .resp_ready(resp_ready1), .resp_instr(resp_instr1), .resp_addr(resp_addr1),
        .resp_fault(resp_fault1), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data)
    );

    typedef struct {
        logic        rv;
        logic [63:0] addr;
        logic        fl;
        logic        rr;
        logic        ld;
        logic [7:0]  la;
        logic [31:0] ldd;
        logic        e_rdy;
        logic        e_val;
        logic [31:0] e_instr;
        logic [63:0] e_addr;
        logic        e_fault;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    function automatic void row(input logic rv, input logic [63:0] addr, input logic fl,
                                input logic rr, input logic ld, input logic [7:0] la,
                                input logic [31:0] ldd, input logic e_rdy, input logic e_val,
                                input logic [31:0] e_instr, input logic [63:0] e_addr,
                                input logic e_fault);
        vec_t v;
        v.rv = rv; v.addr = addr; v.fl = fl; v.rr = rr; v.ld = ld; v.la = la; v.ldd = ldd;
        v.e_rdy = e_rdy; v.e_val = e_val; v.e_instr = e_instr; v.e_addr = e_addr;
        v.e_fault = e_fault;
        vq.push_back(v);
    endfunction

    // Plain fetch with resp_ready held high: valid appears two edges after accept.
    function automatic void fetch4(input logic [63:0] a, input logic [31:0] ins, input logic f);
        row(1, a, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0);
        row(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        row(0, 0, 0, 1, 0, 0, 0, 0, 1, ins, a, f);
        row(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    endfunction

    initial begin
        // Normal fetches
        fetch4(64'h0, 32'hA0, 0);
        fetch4(64'h4, 32'hA1, 0);
        // Faults: misaligned and first out-of-range address
        fetch4(64'h6,   32'h00000013, 1);
        fetch4(64'h400, 32'h00000013, 1);
        // Backpressure for 5 cycles; a pending request must not be accepted
        row(1, 64'h8, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        row(0, 0,     0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        row(0, 0,     0, 0, 0, 0, 0, 0, 1, 32'hA2, 64'h8, 0);
        for (int i = 0; i < 4; i++) row(1, 64'h0, 0, 0, 0, 0, 0, 0, 1, 32'hA2, 64'h8, 0);
        row(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        row(0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0);
        // Flush one cycle after accept cancels the fetch
        row(1, 64'hC, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0);
        row(0, 0,     1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        row(0, 0,     0, 1, 0, 0, 0, 1, 0, 0, 0, 0);
        row(0, 0,     0, 1, 0, 0, 0, 1, 0, 0, 0, 0);
        fetch4(64'h0, 32'hA0, 0);
        // Flush in IDLE blocks acceptance
        row(1, 64'h0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        row(0, 0,     0, 1, 0, 0, 0, 1, 0, 0, 0, 0);
        // Same-edge load to the fetched word is not seen; next fetch sees it
        row(1, 64'h4, 0, 1, 1, 8'd1, 32'hBB, 1, 0, 0, 0, 0);
        row(0, 0,     0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        row(0, 0,     0, 1, 0, 0, 0, 0, 1, 32'hA1, 64'h4, 0);
        row(0, 0,     0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        fetch4(64'h4, 32'hBB, 0);

        reset = 1'b1;
        req_valid = 0; req_addr = '0; flush = 0; resp_ready = 0;
        ld_en = 0; ld_addr = '0; ld_data = '0;
        req_valid1 = 0; req_addr1 = '0; resp_ready1 = 0;
        @(posedge clk); @(posedge clk); #1;
        chk("rst_valid", 64'(resp_valid), 64'd0);
        chk("rst_instr", 64'(resp_instr), 64'd0);
        chk("rst_addr",  resp_addr,       64'd0);
        chk("rst_fault", 64'(resp_fault), 64'd0);
        reset = 1'b0;

        for (int i = 0; i < 4; i++) begin
            ld_en = 1; ld_addr = 8'(i); ld_data = 32'hA0 + 32'(i);
            @(posedge clk); #1;
        end
        ld_en = 0;

        foreach (vq[i]) begin
            req_valid = vq[i].rv; req_addr = vq[i].addr; flush = vq[i].fl;
            resp_ready = vq[i].rr; ld_en = vq[i].ld; ld_addr = vq[i].la; ld_data = vq[i].ldd;
            #1;
            chk($sformatf("v%0d_req_ready", i), 64'(req_ready), 64'(vq[i].e_rdy));
            @(posedge clk); #1;
            chk($sformatf("v%0d_resp_valid", i), 64'(resp_valid), 64'(vq[i].e_val));
            if (vq[i].e_val) begin
                chk($sformatf("v%0d_instr", i), 64'(resp_instr), 64'(vq[i].e_instr));
                chk($sformatf("v%0d_addr", i),  resp_addr,       vq[i].e_addr);
                chk($sformatf("v%0d_fault", i), 64'(resp_fault), 64'(vq[i].e_fault));
            end
        end
        req_valid = 0; flush = 0; ld_en = 0; resp_ready = 1;

        // Reset asserted while BUSY: outputs clear without waiting for a clock
        req_valid = 1; req_addr = 64'h4;
        @(posedge clk); #1;
        req_valid = 0;
        chk("busy_addr_latched", resp_addr, 64'h4);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_valid", 64'(resp_valid), 64'd0);
        chk("async_rst_instr", 64'(resp_instr), 64'd0);
        chk("async_rst_addr",  resp_addr,       64'd0);
        chk("async_rst_fault", 64'(resp_fault), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        chk("post_rst_ready", 64'(req_ready), 64'd1);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk($sformatf("post_rst_no_resp%0d", i), 64'(resp_valid), 64'd0);
        end

        // LATENCY=1 build: response one cycle after accept
        req_valid1 = 1; req_addr1 = 64'h0; resp_ready1 = 1;
        #1;
        chk("l1_req_ready", 64'(req_ready1), 64'd1);
        @(posedge clk); #1;
        req_valid1 = 0;
        chk("l1_valid_k", 64'(resp_valid1), 64'd0);
        @(posedge clk); #1;
        chk("l1_valid_k1", 64'(resp_valid1), 64'd1);
        chk("l1_instr",    64'(resp_instr1), 64'hA0);
        chk("l1_addr",     resp_addr1,       64'h0);
        chk("l1_fault",    64'(resp_fault1), 64'd0);
        @(posedge clk); #1;
        chk("l1_done", 64'(resp_valid1), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1);
    end

endmodule

// File: doc/imem_fetch_responder.md
Name: imem_fetch_responder

Overview:
Instruction-memory responder at the far end of the fetch interface. It accepts a fetch request carrying the 64-bit PC produced by the PC/branch unit, reads a 32-bit instruction word after a fixed configurable latency, and returns it with a valid/ready handshake. Misaligned and out-of-range PCs return a fault. A flush from branch resolution cancels an in-flight fetch. A synchronous load port preloads program memory.

Parameters:
DEPTH, 256, number of 32-bit instruction words; legal byte addresses are 0 .. 4*DEPTH-4
LATENCY, 2, cycles from request acceptance edge to resp_valid; legal range is 1..15
NOP, 32'h00000013, instruction returned on fault (RISC-V addi x0,x0,0)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
req_valid  in  1  fetch request present
req_ready  out  1  responder can accept a request
req_addr  in  64  byte address (PC) to fetch
flush  in  1  cancel any outstanding fetch
resp_valid  out  1  response present
resp_ready  in  1  consumer accepts the response
resp_instr  out  32  fetched instruction, or NOP on fault
resp_addr  out  64  PC of the returned instruction
resp_fault  out  1  misaligned or out-of-range address
ld_en  in  1  program-load write enable
ld_addr  in  $clog2(DEPTH)  word index for the load
ld_data  in  32  word to write

Behaviour:
- Reset is asynchronous and active-high: state=IDLE, resp_valid=0, resp_instr=0, resp_addr=0, resp_fault=0, counter=0. Memory contents are not reset.
- req_ready = (state==IDLE) & ~flush. A request is accepted on a rising edge where req_valid & req_ready.
- FSM states: IDLE, BUSY, RESP.
  - IDLE -> BUSY on accept when LATENCY>1, with counter loaded to LATENCY-1.
  - IDLE -> RESP directly on accept when LATENCY==1.
  - BUSY decrements the counter each cycle and moves to RESP on the edge where the counter reaches 1→0.
  - RESP -> IDLE on the edge where resp_valid & resp_ready.
- Latency: for an accept at edge k, resp_valid rises after edge k+LATENCY.
- The address and fault are latched at the accept edge. The instruction word is read at that same edge with read-before-write semantics: a same-edge ld_en write to that word is not seen.
- Fault: req_addr[1:0]!=0, or req_addr[63:2] >= DEPTH → resp_fault=1 and resp_instr=NOP. No memory access is made, and fault latency equals normal latency.
- In RESP, resp_instr, resp_addr and resp_fault hold stable until the handshake. Backpressure is unlimited. No request is accepted in BUSY or RESP; one transaction is outstanding at a time.
- flush=1 in BUSY or RESP: go to IDLE on the next edge, drop resp_valid, and discard the transaction with no response. Flush has priority over a simultaneous resp_ready.
- flush=1 in IDLE: blocks acceptance that cycle.
- The load port writes mem[ld_addr] <= ld_data on any edge with ld_en, in any state.
- Reset mid-transaction: return immediately to the reset values; the pending fetch is lost.

Test Plan:
- Load mem[0..3]={0xA0,0xA1,0xA2,0xA3}, LATENCY=2, reset. Fetch 0x0 then 0x4 with resp_ready=1 → resp_valid 2 cycles after each accept with instr 0xA0/0xA1 and resp_addr 0x0/0x4, fault=0; req_ready low while busy.
- Fetch 0x6 (misaligned) and 0x400 (=4*DEPTH) → resp_fault=1, resp_instr=0x00000013, both at 2-cycle latency.
- Fetch 0x8 with resp_ready=0 for 5 cycles → resp_valid, instr 0xA2 and addr 0x8 stay stable; req_ready stays 0; IDLE after the handshake.
- Fetch 0xC, assert flush 1 cycle after accept → no resp_valid ever; req_ready=1 the cycle after flush; next fetch 0x0 returns 0xA0.
- Same edge: accept 0x4 and ld_en writing word 1=0xBB → response 0xA1. A subsequent fetch of 0x4 → 0xBB.
- Assert reset during BUSY → outputs zero asynchronously, no response, req_ready=1 after reset release; LATENCY=1 build returns 0xA0 one cycle after accept.
